key_step_debouncer: RTL and testbench



---
 rtl/key_step_debouncer.sv | 132 +++++++++++++
 tb/tb_key_step_debouncer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/key_step_debouncer.sv
// Push-button front end: two-flop synchroniser, debounce FSM and auto-repeat.
// Emits registered single-cycle press/release/step pulses for a clock-enabled counter.
module key_step_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter int TIMER_W         = 32
) (
  input  logic clk,
  input  logic clear,
  input  logic key_n,
  input  logic repeat_en,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic step
);

  typedef enum logic [2:0] {IDLE, DB_PRESS, HELD, REPEAT, DB_RELEASE} state_t;

  localparam logic [TIMER_W-1:0] DB_T  = TIMER_W'(DEBOUNCE_CYCLES);
  localparam logic [TIMER_W-1:0] RD_T  = TIMER_W'(REPEAT_DELAY - 1);
  localparam logic [TIMER_W-1:0] RR_T  = TIMER_W'(REPEAT_RATE - 1);
  localparam logic [TIMER_W-1:0] ONE_T = TIMER_W'(1);

  logic [1:0]         sync_q, sync_d;
  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               pressed_q, pressed_d;
  logic               press_q, press_d;
  logic               rel_q, rel_d;
  logic               step_q, step_d;
  logic               act;

  assign sync_d = {sync_q[0], key_n};
  assign act    = ~sync_q[1];

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + ONE_T;
    press_d = 1'b0;
    rel_d   = 1'b0;
    step_d  = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (act) begin
          state_d = DB_PRESS;
          timer_d = ONE_T;
        end
      end
      DB_PRESS: begin
        if (!act) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == DB_T) begin
          state_d = HELD;
          timer_d = '0;
          press_d = 1'b1;
          step_d  = 1'b1;
        end
      end
      HELD: begin
        if (!act) begin
          state_d = DB_RELEASE;
          timer_d = ONE_T;
        end else if (timer_q == RD_T) begin
          // Without repeat the delay timer parks here so enabling repeat later steps at once.
          timer_d = timer_q;
          if (repeat_en) begin
            state_d = REPEAT;
            timer_d = '0;
            step_d  = 1'b1;
          end
        end
      end
      REPEAT: begin
        if (!act) begin
          state_d = DB_RELEASE;
          timer_d = ONE_T;
        end else if (!repeat_en) begin
          state_d = HELD;
          timer_d = '0;
        end else if (timer_q == RR_T) begin
          timer_d = '0;
          step_d  = 1'b1;
        end
      end
      DB_RELEASE: begin
        if (act) begin
          state_d = HELD;
          timer_d = '0;
        end else if (timer_q == DB_T) begin
          state_d = IDLE;
          timer_d = '0;
          rel_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
    pressed_d = (state_d == HELD) || (state_d == REPEAT) || (state_d == DB_RELEASE);
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      sync_q    <= 2'b11;
      state_q   <= IDLE;
      timer_q   <= '0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      rel_q     <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      rel_q     <= rel_d;
      step_q    <= step_d;
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign step          = step_q;

endmodule

// File: tb/tb_key_step_debouncer.sv
// Scoreboard bench: a run-length reference model predicts every output cycle,
// a negedge monitor pops and compares; plus an 8-bit counter driven by step.
module tb_key_step_debouncer;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic clk = 1'b0;
  logic clear, key_n, repeat_en;
  logic pressed, press_pulse, release_pulse, step;

  key_step_debouncer #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .TIMER_W(32)
  ) dut (
    .clk(clk), .clear(clear), .key_n(key_n), .repeat_en(repeat_en),
    .pressed(pressed), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .step(step)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pressed;
    logic pp;
    logic rp;
    logic st;
  } out_t;

  out_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pp_seen  = 0;
  logic [7:0] cnt;

  // Counter consuming step as its enable.
  always @(posedge clk or posedge clear)
    if (clear) cnt <= 8'h00;
    else if (step) cnt <= cnt + 8'h01;

  // Reference model: key accepted after D+1 consecutive synchronised samples
  // at the new level; repeat counted in edges since the hold was (re)armed.
  logic m_s1, m_s2;
  bit   m_pressed, m_rep;
  int   m_run, m_age;

  task automatic model_reset();
    m_s1 = 1'b1; m_s2 = 1'b1;
    m_pressed = 0; m_rep = 0; m_run = 0; m_age = 0;
  endtask

  initial model_reset();
  always @(posedge clear) model_reset();

  always @(posedge clk) begin
    out_t e;
    bit act;
    e = '0;
    if (clear) begin
      model_reset();
    end else begin
      act = ~m_s2;
      if (!m_pressed) begin
        m_run = act ? m_run + 1 : 0;
        if (m_run == D + 1) begin
          m_pressed = 1; m_run = 0; m_age = 0; m_rep = 0;
          e.pp = 1; e.st = 1;
        end
      end else if (!act) begin
        m_run++;
        if (m_run == D + 1) begin
          m_pressed = 0; m_run = 0; e.rp = 1;
        end
      end else if (m_run > 0) begin
        m_run = 0; m_age = 0; m_rep = 0;
      end else begin
        m_age++;
        if (!m_rep) begin
          if (repeat_en && m_age >= RD) begin
            m_rep = 1; m_age = 0; e.st = 1;
          end
        end else if (!repeat_en) begin
          m_rep = 0; m_age = 0;
        end else if (m_age == RR) begin
          m_age = 0; e.st = 1;
        end
      end
      m_s2 = m_s1;
      m_s1 = key_n;
    end
    e.pressed = m_pressed;
    exp_q.push_back(e);
  end

  // Monitor: one expected record per cycle; async clear forces all-zero outputs.
  always @(negedge clk) begin
    out_t e, a;
    a = {pressed, press_pulse, release_pulse, step};
    if (press_pulse) pp_seen++;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL queue_empty t=%0t got %b required an expected entry", $time, a);
    end else begin
      e = exp_q.pop_front();
      if (clear) e = '0;
      if (a !== e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t got {prs,pp,rp,st}=%b required %b", $time, a, e);
      end
    end
  end

  task automatic hold(input logic k, input int n);
    key_n = k;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check(input string name, input int got, input int req);
    n_checks++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  initial begin
    int pp0;
    clear = 1'b1; key_n = 1'b1; repeat_en = 1'b0;
    repeat (3) @(posedge clk);
    #2 clear = 1'b0;
    hold(1, 4);

    // Clean press, no repeat
    hold(0, 30);
    hold(1, 15);

    // Bounce shorter than the debounce window
    pp0 = pp_seen;
    hold(0, 3); hold(1, 5); hold(0, 2); hold(1, 12);
    check("bounce_no_press", pp_seen - pp0, 0);
    check("bounce_released", int'(pressed), 0);

    // Auto-repeat then release
    repeat_en = 1'b1;
    hold(0, 31);
    hold(1, 15);

    // Release bounce returns silently to held
    repeat_en = 1'b0;
    hold(0, 12); hold(1, 2); hold(0, 10);
    check("rel_bounce_pressed", int'(pressed), 1);
    hold(1, 12);

    // Clear during debounce with key held
    hold(0, 4);
    clear = 1'b1;
    #1 check("clear_async_pressed", int'(pressed), 0);
    hold(0, 2);
    clear = 1'b0;
    hold(0, 12);
    check("held_through_clear", int'(pressed), 1);
    hold(1, 12);

    // Counter hookup: 17 clean presses
    clear = 1'b1;
    hold(1, 2);
    clear = 1'b0;
    repeat (17) begin
      hold(0, 8);
      hold(1, 8);
    end
    check("counter_17", int'(cnt), 17);

    // Randomized segments, including repeat toggling and occasional clear
    for (int i = 0; i < 150; i++) begin
      repeat_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        clear = 1'b1;
        hold(key_n, 1);
        clear = 1'b0;
      end
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 14));
    end
    hold(1, 12);
    check("final_released", int'(pressed), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
